// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM sequencer: FSM encoding, table entry layout and widths.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_FIRE      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } seq_state_t;

  localparam int ENTRY_W   = 24;
  localparam int DELAY_LSB = 0;
  localparam int DELAY_W   = 16;
  localparam int CH_LSB    = 16;
  localparam int CH_W      = 8;
  localparam int LEN_W     = 8;
  localparam int LOOP_W    = 8;

  function automatic logic [DELAY_W-1:0] entry_delay(input logic [ENTRY_W-1:0] e);
    return e[DELAY_LSB +: DELAY_W];
  endfunction

  function automatic logic [CH_W-1:0] entry_ch(input logic [ENTRY_W-1:0] e);
    return e[CH_LSB +: CH_W];
  endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// Step table register file: one write port, one asynchronous read port, reset to all-zero entries.
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int _STEPS = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [_STEPS];
  logic [ENTRY_W-1:0] mem_d [_STEPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < _STEPS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Steps through a table of {channel, delay} entries, triggering PWM channels and tracking their busy handshake.
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int _NUM_CHANNELS = 3,
  parameter int _STEPS        = 8,
  parameter int _ACK_TO       = 1024
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  input  logic                        cfg_wr,
  input  logic [$clog2(_STEPS)-1:0]   cfg_addr,
  input  logic [ENTRY_W-1:0]          cfg_data,
  input  logic [LEN_W-1:0]            seq_len,
  input  logic [LOOP_W-1:0]           loop_num,
  input  logic                        seq_start,
  input  logic                        seq_abort,
  input  logic [_NUM_CHANNELS-1:0]    pwm_busy,
  output logic [_NUM_CHANNELS-1:0]    pwm_en,
  output logic                        seq_busy,
  output logic                        seq_done,
  output logic                        seq_err,
  output logic [$clog2(_STEPS)-1:0]   cur_step
);

  localparam int ADDR_W = $clog2(_STEPS);
  localparam int LQ_W   = LEN_W + 1;
  localparam int ACK_W  = $clog2(_ACK_TO + 1);
  // Timeout fires on the edge _ACK_TO cycles after the trigger edge (one FIRE cycle precedes WAIT_ACK).
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(_ACK_TO - 2);

  seq_state_t              state_q, state_d;
  logic [DELAY_W-1:0]      cnt_q, cnt_d;
  logic                    ld_q, ld_d;
  logic [ACK_W-1:0]        ack_q, ack_d;
  logic [LQ_W-1:0]         len_q, len_d;
  logic [LOOP_W-1:0]       loop_q, loop_d;
  logic [ADDR_W-1:0]       step_q, step_d;
  logic [_NUM_CHANNELS-1:0] en_q, en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [ENTRY_W-1:0]      rd_entry;
  logic [CH_W-1:0]         ch;
  logic                    ch_valid;
  logic                    ch_busy;
  logic [_NUM_CHANNELS-1:0] ch_onehot;
  logic                    last_step;
  logic                    tbl_wr;

  assign tbl_wr = cfg_wr && (state_q == ST_IDLE);

  pwm_seq_table #(
    ._STEPS (_STEPS),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .wr_en   (tbl_wr),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (step_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    ch        = entry_ch(rd_entry);
    ch_valid  = 1'b0;
    ch_busy   = 1'b0;
    ch_onehot = '0;
    for (int i = 0; i < _NUM_CHANNELS; i++) begin
      if (ch == CH_W'(i)) begin
        ch_valid     = 1'b1;
        ch_busy      = pwm_busy[i];
        ch_onehot[i] = 1'b1;
      end
    end
  end

  assign last_step = (LQ_W'(step_q) + LQ_W'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    ack_d   = ack_q;
    len_d   = len_q;
    loop_d  = loop_q;
    step_d  = step_q;
    en_d    = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (seq_start && !seq_abort) begin
          err_d  = 1'b0;
          len_d  = ({1'b0, seq_len} > LQ_W'(_STEPS)) ? LQ_W'(_STEPS) : {1'b0, seq_len};
          loop_d = loop_num;
          step_d = '0;
          if (len_d == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DELAY;
            ld_d    = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (ld_q) begin
          cnt_d = entry_delay(rd_entry);
          ld_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_FIRE;
          en_d    = ch_onehot;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIRE: begin
        if (ch_valid) begin
          state_d = ST_WAIT_ACK;
          ack_d   = '0;
        end else begin
          err_d   = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_WAIT_ACK: begin
        if (ch_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_q == ACK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!ch_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = ST_DELAY;
        ld_d    = 1'b1;
        if (last_step) begin
          step_d = '0;
          // loop_q of 0 means endless; 1 means this was the final pass.
          if (loop_q == LOOP_W'(1)) begin
            state_d = ST_IDLE;
            ld_d    = 1'b0;
            done_d  = 1'b1;
          end else if (loop_q != '0) begin
            loop_d = loop_q - 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (seq_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      en_d    = '0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      ack_q   <= '0;
      len_q   <= '0;
      loop_q  <= '0;
      step_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      ack_q   <= ack_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      step_q  <= step_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pwm_en   = en_q;
  assign seq_busy = busy_q;
  assign seq_done = done_q;
  assign seq_err  = err_q;
  assign cur_step = step_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl with a 10-cycle busy responder per channel.
module tb_pwm_seq_ctrl;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [23:0] cfg_data = '0;
  logic [7:0]  seq_len = '0;
  logic [7:0]  loop_num = '0;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic [2:0]  pwm_busy = '0;
  logic [2:0]  pwm_en;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [2:0]  cur_step;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic busy_hold0 = 1'b0;

  int en_cnt_ch [3] = '{0, 0, 0};
  int en_time   [3] = '{0, 0, 0};
  int en_total = 0;
  int done_cnt = 0;
  int done_time = 0;
  int bcnt [3] = '{0, 0, 0};

  pwm_seq_ctrl #(._NUM_CHANNELS(3), ._STEPS(8), ._ACK_TO(1024)) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .seq_len  (seq_len),
    .loop_num (loop_num),
    .seq_start(seq_start),
    .seq_abort(seq_abort),
    .pwm_busy (pwm_busy),
    .pwm_en   (pwm_en),
    .seq_busy (seq_busy),
    .seq_done (seq_done),
    .seq_err  (seq_err),
    .cur_step (cur_step)
  );

  initial forever #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  // Event log: cycle numbers refer to the posedge that produced the value.
  always @(negedge clk_50M) begin
    for (int i = 0; i < 3; i++) begin
      if (pwm_en[i]) begin
        en_cnt_ch[i] = en_cnt_ch[i] + 1;
        en_time[i]   = cyc;
      end
    end
    if (pwm_en != 3'b000) en_total = en_total + 1;
    if (seq_done) begin
      done_cnt  = done_cnt + 1;
      done_time = cyc;
    end
  end

  // Busy responder: busy for 10 cycles after seeing the trigger, unless held low.
  always @(negedge clk_50M) begin
    for (int k = 0; k < 3; k++) begin
      if (!busy_hold0 && pwm_en[k]) bcnt[k] = 10;
      else if (bcnt[k] != 0) bcnt[k] = bcnt[k] - 1;
      pwm_busy[k] = (bcnt[k] != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] ch, input logic [15:0] dly);
    cfg_addr = a;
    cfg_data = {ch, dly};
    cfg_wr   = 1'b1;
    tick(1);
    cfg_wr   = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] len, input logic [7:0] loops, output int s);
    seq_len   = len;
    loop_num  = loops;
    seq_start = 1'b1;
    tick(1);
    s = cyc;
    seq_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (seq_busy && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: seq_busy=%0b after %0d cycles, required 0", name, seq_busy, budget);
    end
    tick(3);
  endtask

  task automatic test_reset();
    int s, e0, d0;
    rst_n = 1'b0;
    tick(3);
    checks++; if (pwm_en !== 3'b000) begin errors++; $display("FAIL rst_pwm_en: got %b want 000", pwm_en); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_seq_busy: got %b want 0", seq_busy); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL rst_seq_done: got %b want 0", seq_done); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_seq_err: got %b want 0", seq_err); end
    checks++; if (cur_step !== 3'd0) begin errors++; $display("FAIL rst_cur_step: got %0d want 0", cur_step); end
    rst_n = 1'b1;
    tick(2);
    // Unwritten slot 0 is {ch=0, delay=0}: trigger ch0 two cycles after start.
    e0 = en_cnt_ch[0]; d0 = done_cnt;
    do_start(8'd1, 8'd1, s);
    wait_idle(100, "reset_default");
    checks++; if (en_cnt_ch[0] - e0 !== 1) begin errors++; $display("FAIL rst_tbl_en0_cnt: got %0d want 1", en_cnt_ch[0] - e0); end
    checks++; if (en_time[0] !== s + 2) begin errors++; $display("FAIL rst_tbl_en0_time: got %0d want %0d", en_time[0], s + 2); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rst_tbl_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++; if (done_time !== s + 14) begin errors++; $display("FAIL rst_tbl_done_time: got %0d want %0d", done_time, s + 14); end
  endtask

  task automatic test_basic();
    int s, e0, e1, e2, et, d0;
    cfg_write(3'd0, 8'd0, 16'd5);
    cfg_write(3'd1, 8'd1, 16'd0);
    cfg_write(3'd2, 8'd2, 16'd3);
    e0 = en_cnt_ch[0]; e1 = en_cnt_ch[1]; e2 = en_cnt_ch[2]; et = en_total; d0 = done_cnt;
    do_start(8'd3, 8'd1, s);
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_on_start: got %b want 1", seq_busy); end
    checks++; if (cur_step !== 3'd0) begin errors++; $display("FAIL basic_step_on_start: got %0d want 0", cur_step); end
    wait_idle(200, "basic");
    checks++; if (en_time[0] !== s + 7) begin errors++; $display("FAIL basic_en0_time: got %0d want %0d", en_time[0], s + 7); end
    checks++; if (en_time[1] !== s + 21) begin errors++; $display("FAIL basic_en1_time: got %0d want %0d", en_time[1], s + 21); end
    checks++; if (en_time[2] !== s + 38) begin errors++; $display("FAIL basic_en2_time: got %0d want %0d", en_time[2], s + 38); end
    checks++; if ((en_cnt_ch[0] - e0) + (en_cnt_ch[1] - e1) + (en_cnt_ch[2] - e2) !== 3)
      begin errors++; $display("FAIL basic_en_pulses: got %0d want 3", (en_cnt_ch[0] - e0) + (en_cnt_ch[1] - e1) + (en_cnt_ch[2] - e2)); end
    checks++; if (en_total - et !== 3) begin errors++; $display("FAIL basic_en_cycles: got %0d want 3", en_total - et); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++; if (done_time !== s + 50) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_time, s + 50); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", seq_err); end
  endtask

  task automatic test_bad_channel();
    int s, e0, et, d0;
    cfg_write(3'd1, 8'd5, 16'd0);
    e0 = en_cnt_ch[0]; et = en_total; d0 = done_cnt;
    do_start(8'd2, 8'd1, s);
    wait_idle(200, "badch");
    checks++; if (en_cnt_ch[0] - e0 !== 1) begin errors++; $display("FAIL badch_en0_cnt: got %0d want 1", en_cnt_ch[0] - e0); end
    checks++; if (en_time[0] !== s + 7) begin errors++; $display("FAIL badch_en0_time: got %0d want %0d", en_time[0], s + 7); end
    checks++; if (en_total - et !== 1) begin errors++; $display("FAIL badch_en_total: got %0d want 1", en_total - et); end
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL badch_err: got %b want 1", seq_err); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL badch_done_cnt: got %0d want 1", done_cnt - d0); end
    checks++; if (done_time !== s + 23) begin errors++; $display("FAIL badch_done_time: got %0d want %0d", done_time, s + 23); end
  endtask

  task automatic test_ack_timeout();
    int s, n, t, et, d0;
    busy_hold0 = 1'b1;
    et = en_total; d0 = done_cnt;
    do_start(8'd1, 8'd1, s);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL ackto_err_cleared: got %b want 0", seq_err); end
    n = 0;
    while (!seq_err && n < 1200) begin
      tick(1);
      n++;
    end
    t = cyc;
    checks++; if (t !== s + 1031) begin errors++; $display("FAIL ackto_err_time: got %0d want %0d", t, s + 1031); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL ackto_idle: seq_busy got %b want 0", seq_busy); end
    tick(3);
    checks++; if (en_total - et !== 1) begin errors++; $display("FAIL ackto_en_total: got %0d want 1", en_total - et); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ackto_no_done: got %0d want 0", done_cnt - d0); end
    busy_hold0 = 1'b0;
    tick(2);
  endtask

  task automatic test_abort_endless();
    int s, n, e0, et, d0;
    cfg_write(3'd1, 8'd1, 16'd0);
    e0 = en_cnt_ch[0]; et = en_total; d0 = done_cnt;
    do_start(8'd3, 8'd0, s);
    n = 0;
    while ((en_cnt_ch[0] - e0) < 3 && n < 400) begin
      tick(1);
      n++;
    end
    checks++; if (en_cnt_ch[0] - e0 !== 3) begin errors++; $display("FAIL abort_loop3_reached: got %0d want 3", en_cnt_ch[0] - e0); end
    tick(3);
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", seq_busy); end
    seq_abort = 1'b1;
    tick(1);
    seq_abort = 1'b0;
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL abort_idle_next: seq_busy got %b want 0", seq_busy); end
    tick(20);
    checks++; if (en_total - et !== 7) begin errors++; $display("FAIL abort_en_total: got %0d want 7", en_total - et); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", seq_err); end
  endtask

  task automatic test_cfg_locked();
    int s, s2, e2;
    do_start(8'd3, 8'd1, s);
    tick(2);
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL lock_busy: got %b want 1", seq_busy); end
    cfg_write(3'd0, 8'd2, 16'd1);
    wait_idle(200, "lock_run1");
    checks++; if (en_time[0] !== s + 7) begin errors++; $display("FAIL lock_tbl_after_abort_en0: got %0d want %0d", en_time[0], s + 7); end
    checks++; if (en_time[2] !== s + 38) begin errors++; $display("FAIL lock_tbl_after_abort_en2: got %0d want %0d", en_time[2], s + 38); end
    e2 = en_cnt_ch[2];
    do_start(8'd1, 8'd1, s2);
    wait_idle(100, "lock_run2");
    checks++; if (en_time[0] !== s2 + 7) begin errors++; $display("FAIL lock_slot0_kept: en0 time got %0d want %0d", en_time[0], s2 + 7); end
    checks++; if (en_cnt_ch[2] - e2 !== 0) begin errors++; $display("FAIL lock_no_en2: got %0d want 0", en_cnt_ch[2] - e2); end
  endtask

  task automatic test_zero_len();
    int s, et, d0;
    et = en_total; d0 = done_cnt;
    seq_len = 8'd2; loop_num = 8'd1;
    seq_start = 1'b1; seq_abort = 1'b1;
    tick(1);
    seq_start = 1'b0; seq_abort = 1'b0;
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL startabort_busy: got %b want 0", seq_busy); end
    tick(4);
    checks++; if (en_total - et !== 0) begin errors++; $display("FAIL startabort_no_en: got %0d want 0", en_total - et); end
    do_start(8'd0, 8'd1, s);
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL zlen_done_pulse: got %b want 1", seq_done); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL zlen_busy: got %b want 0", seq_busy); end
    tick(1);
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL zlen_done_width: got %b want 0", seq_done); end
    tick(10);
    checks++; if (en_total - et !== 0) begin errors++; $display("FAIL zlen_no_en: got %0d want 0", en_total - et); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zlen_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_in_delay();
    int s, n, e0, et, d0;
    cfg_write(3'd1, 8'd1, 16'd20);
    e0 = en_cnt_ch[0];
    do_start(8'd2, 8'd1, s);
    n = 0;
    while ((en_cnt_ch[0] - e0) < 1 && n < 100) begin
      tick(1);
      n++;
    end
    tick(15);
    checks++; if (cur_step !== 3'd1) begin errors++; $display("FAIL rdly_step_before: got %0d want 1", cur_step); end
    et = en_total; d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    checks++; if (pwm_en !== 3'b000) begin errors++; $display("FAIL rdly_pwm_en: got %b want 000", pwm_en); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rdly_busy: got %b want 0", seq_busy); end
    checks++; if (cur_step !== 3'd0) begin errors++; $display("FAIL rdly_step: got %0d want 0", cur_step); end
    checks++; if ({seq_done, seq_err} !== 2'b00) begin errors++; $display("FAIL rdly_done_err: got %b want 00", {seq_done, seq_err}); end
    tick(2);
    rst_n = 1'b1;
    tick(40);
    checks++; if (en_total - et !== 0) begin errors++; $display("FAIL rdly_no_en_after: got %0d want 0", en_total - et); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rdly_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rdly_idle_after: got %b want 0", seq_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_channel();
    test_ack_timeout();
    test_abort_endless();
    test_cfg_locked();
    test_zero_len();
    test_reset_in_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 SHALL have parameter _NUM_CHANNELS, default 3, number of PWM channels sequenced.
REQ-002 SHALL have parameter _STEPS, default 8, sequence table depth (power of 2).
REQ-003 SHALL have parameter _ACK_TO, default 1024, clk_50M cycles allowed for pwm_busy to rise after a trigger.
REQ-004 SHALL have port clk_50M  in  1  the single clock for all logic.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_wr  in  1  one-cycle table write strobe.
REQ-007 SHALL have port cfg_addr  in  log2(_STEPS)  table slot index.
REQ-008 SHALL have port cfg_data  in  24  {ch[7:0], delay[15:0]} step entry.
REQ-009 SHALL have port seq_len  in  8  number of active steps, sampled at start.
REQ-010 SHALL have port loop_num  in  8  sequence repetitions, 0 = endless, sampled at start.
REQ-011 SHALL have port seq_start  in  1  one-cycle start strobe.
REQ-012 SHALL have port seq_abort  in  1  one-cycle abort strobe.
REQ-013 SHALL have port pwm_busy  in  _NUM_CHANNELS  per-channel busy from the PWM generators.
REQ-014 SHALL have port pwm_en  out  _NUM_CHANNELS  per-channel one-cycle trigger.
REQ-015 SHALL have port seq_busy  out  1  high from start acceptance until return to IDLE.
REQ-016 SHALL have port seq_done  out  1  one-cycle pulse on normal completion.
REQ-017 SHALL have port seq_err  out  1  sticky error flag, cleared by the next accepted start.
REQ-018 SHALL have port cur_step  out  log2(_STEPS)  index of the step in progress.

Function
REQ-019 SHALL implement states IDLE, DELAY, FIRE, WAIT_ACK, WAIT_DONE, NEXT.
REQ-020 SHALL write cfg_data into slot cfg_addr on cfg_wr only in IDLE; writes in any other state are dropped.
REQ-021 SHALL accept seq_start only in IDLE: clear seq_err, latch seq_len (clamped to _STEPS) and loop_num, set cur_step=0, enter DELAY on the next edge.
REQ-022 SHALL, when latched seq_len=0, pulse seq_done one cycle after start and stay IDLE.
REQ-023 SHALL load the step delay D in DELAY and count down; DELAY→FIRE when the count is 0, so pwm_en asserts D+2 cycles after the start edge for step 0.
REQ-024 SHALL drive pwm_en[ch] high for exactly one cycle in FIRE, then enter WAIT_ACK.
REQ-025 SHALL treat ch ≥ _NUM_CHANNELS as invalid: no trigger, seq_err set, go to NEXT.
REQ-026 SHALL leave WAIT_ACK for WAIT_DONE when pwm_busy[ch]=1; after _ACK_TO cycles without it, set seq_err and return to IDLE without seq_done.
REQ-027 SHALL leave WAIT_DONE for NEXT when pwm_busy[ch]=0 (no timeout in WAIT_DONE).
REQ-028 SHALL in NEXT increment cur_step; at seq_len-1 wrap to 0 and decrement the loop count; when the final loop ends pulse seq_done and enter IDLE; with loop_num=0 wrap forever.
REQ-029 SHALL honour seq_abort in any non-IDLE state: IDLE next edge, pwm_en forced 0, no seq_done, seq_err unchanged.
REQ-030 SHALL give seq_abort priority over every same-cycle transition, including a pending seq_done.
REQ-031 SHALL ignore seq_start coincident with seq_abort in IDLE.

Reset
REQ-032 SHALL on rst_n low asynchronously set state IDLE, pwm_en=0, seq_busy=0, seq_done=0, seq_err=0, cur_step=0, all counters 0.
REQ-033 SHALL reset all table slots to {ch=0, delay=0}.
REQ-034 SHALL, on reset mid-sequence, not emit any pwm_en pulse after rst_n releases until a new seq_start.

Structure
REQ-035 SHALL place state encoding, the 24-bit entry field positions and width constants in shared package pwm_seq_pkg.
REQ-036 SHALL implement the table as one sub-module pwm_seq_table (_STEPS×24 register file, write port plus one asynchronous read port).
REQ-037 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-038 SHALL cover: slots 0..2 = {0,5},{1,0},{2,3}, seq_len=3, loop_num=1, busy models 10 cycles → pwm_en[0] at start+7, then [1], [2] in order, one seq_done.
REQ-039 SHALL cover: ch=5 in slot 1, seq_len=2 → no pwm_en for slot 1, seq_err=1, seq_done still pulses.
REQ-040 SHALL cover: pwm_busy held 0 after trigger → seq_err at trigger+_ACK_TO, no seq_done, IDLE.
REQ-041 SHALL cover: loop_num=0, abort during WAIT_DONE of loop 3 → IDLE next cycle, no seq_done, table unchanged.
REQ-042 SHALL cover: cfg_wr while seq_busy=1 → slot unchanged; seq_len=0 → seq_done one cycle after start, no pwm_en.
REQ-043 SHALL cover: rst_n asserted in DELAY → all outputs 0 immediately, no pwm_en after release.
